// File: rtl/stream_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_regs_pkg
// Description : Register offsets and bit positions shared by the stream
//               register bridge and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_regs_pkg;

  // Per-channel register offsets (addr[3:0])
  localparam logic [3:0] c_OFF_TXDATA = 4'h0;
  localparam logic [3:0] c_OFF_STATUS = 4'h4;
  localparam logic [3:0] c_OFF_RXDATA = 4'h8;
  localparam logic [3:0] c_OFF_CTRL   = 4'hC;

  // Global interrupt-pending register (only decoded with STREAM_REGS_IRQ_EN)
  localparam logic [7:0] c_ADDR_IRQPEND = 8'hFC;

  // STATUS bit positions
  localparam int c_ST_TX_EMPTY     = 0;
  localparam int c_ST_TX_FULL      = 1;
  localparam int c_ST_RX_NONEMPTY  = 2;
  localparam int c_ST_TX_OVF       = 3;
  localparam int c_ST_TX_COUNT_LSB = 8;
  localparam int c_ST_RX_COUNT_LSB = 16;

  // CTRL bit positions
  localparam int c_CTRL_TX_FLUSH = 0;
  localparam int c_CTRL_RX_FLUSH = 1;
  localparam int c_CTRL_IRQ_EN   = 2;

  // RXDATA empty flag position
  localparam int c_RXDATA_EMPTY = 31;

endpackage
`default_nettype wire

// File: rtl/stream_regs_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Show-ahead byte FIFO with occupancy count and one-cycle
//               flush. A push into a full FIFO is dropped even when a pop
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign dout      = r_mem[r_rptr];
  assign count     = r_count;

  // Pointer and occupancy tracking; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/stream_regs.sv
`default_nettype none
// ============================================================================
// Module      : stream_regs
// Description : Memory-mapped register bridge between the CPU register bus
//               and NCHAN byte-stream peripherals. Each channel has a TX and
//               an RX FIFO, STATUS and CTRL registers.
//               Optional macro STREAM_REGS_IRQ_EN adds the irq output, the
//               CTRL irq-enable bit and the global pending register at 0xFC.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_regs
  import stream_regs_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_req,
  input  logic               reg_wr,
  input  logic [7:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic               reg_ack,
  output logic [31:0]        reg_rdata,
  output logic [NCHAN-1:0]   tx_valid,
  output logic [8*NCHAN-1:0] tx_data,
  input  logic [NCHAN-1:0]   tx_ready,
  input  logic [NCHAN-1:0]   rx_valid,
  input  logic [8*NCHAN-1:0] rx_data,
  output logic [NCHAN-1:0]   rx_ready
`ifdef STREAM_REGS_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic        w_mapped;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_ch;
  logic [3:0]  w_off;
  logic [31:0] w_rdata;
  logic [31:0] w_status [NCHAN];
  logic [31:0] w_rxword [NCHAN];
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        w_unused;
`ifdef STREAM_REGS_IRQ_EN
  logic [NCHAN-1:0] w_irq_en;
  logic [NCHAN-1:0] w_pend;
  logic             r_irq;
`endif

  // Channel windows are 16 bytes each starting at 0x00
  assign w_ch     = reg_addr[6:4];
  assign w_off    = reg_addr[3:0];
  assign w_mapped = ({1'b0, reg_addr} < 9'(16 * NCHAN));
  assign w_wr     = reg_req && reg_wr;
  assign w_rd     = reg_req && !reg_wr;
  assign w_unused = &{1'b0, reg_wdata[31:8]};

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic          w_sel;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_tx_flush;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_rx_flush;
    logic          w_ovf_clr;
    logic [7:0]    w_tx_dout;
    logic [7:0]    w_rx_dout;
    logic [CW-1:0] w_tx_count;
    logic [CW-1:0] w_rx_count;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          r_tx_ovf;
    logic [31:0]   w_status_c;

    assign w_sel      = w_mapped && (w_ch == 3'(c));
    assign w_tx_push  = w_wr && w_sel && (w_off == c_OFF_TXDATA);
    assign w_tx_pop   = tx_valid[c] && tx_ready[c];
    assign w_tx_flush = w_wr && w_sel && (w_off == c_OFF_CTRL) && reg_wdata[c_CTRL_TX_FLUSH];
    assign w_rx_push  = rx_valid[c] && rx_ready[c];
    assign w_rx_pop   = w_rd && w_sel && (w_off == c_OFF_RXDATA);
    assign w_rx_flush = w_wr && w_sel && (w_off == c_OFF_CTRL) && reg_wdata[c_CTRL_RX_FLUSH];
    assign w_ovf_clr  = w_wr && w_sel && (w_off == c_OFF_STATUS) && reg_wdata[c_ST_TX_OVF];

    byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (w_tx_flush),
      .push  (w_tx_push),
      .din   (reg_wdata[7:0]),
      .pop   (w_tx_pop),
      .dout  (w_tx_dout),
      .count (w_tx_count),
      .full  (w_tx_full),
      .empty (w_tx_empty)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (w_rx_flush),
      .push  (w_rx_push),
      .din   (rx_data[8*c +: 8]),
      .pop   (w_rx_pop),
      .dout  (w_rx_dout),
      .count (w_rx_count),
      .full  (w_rx_full),
      .empty (w_rx_empty)
    );

    assign tx_valid[c]       = !w_tx_empty;
    assign tx_data[8*c +: 8] = w_tx_dout;
    assign rx_ready[c]       = !w_rx_full;

    // Sticky TX overflow: a dropped byte wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_tx_ovf <= 1'b0;
      else if (w_tx_push && w_tx_full) r_tx_ovf <= 1'b1;
      else if (w_ovf_clr)              r_tx_ovf <= 1'b0;
    end

    // Assemble the STATUS word for this channel
    always_comb begin
      w_status_c = '0;
      w_status_c[c_ST_TX_EMPTY]              = w_tx_empty;
      w_status_c[c_ST_TX_FULL]               = w_tx_full;
      w_status_c[c_ST_RX_NONEMPTY]           = !w_rx_empty;
      w_status_c[c_ST_TX_OVF]                = r_tx_ovf;
      w_status_c[c_ST_TX_COUNT_LSB +: 8]     = 8'(w_tx_count);
      w_status_c[c_ST_RX_COUNT_LSB +: 8]     = 8'(w_rx_count);
    end

    assign w_status[c] = w_status_c;
    assign w_rxword[c] = {w_rx_empty, 23'b0, (w_rx_empty ? 8'h00 : w_rx_dout)};

`ifdef STREAM_REGS_IRQ_EN
    logic r_irq_en;

    // Interrupt enable bit, written through CTRL
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_irq_en <= 1'b0;
      else if (w_wr && w_sel && (w_off == c_OFF_CTRL)) r_irq_en <= reg_wdata[c_CTRL_IRQ_EN];
    end

    assign w_irq_en[c] = r_irq_en;
    assign w_pend[c]   = r_irq_en && (!w_rx_empty || r_tx_ovf);
`endif
  end

  // Read-data selection for the register addressed this cycle
  always_comb begin
    w_rdata = '0;
    if (w_mapped) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (w_ch == 3'(i)) begin
          case (w_off)
            c_OFF_STATUS: w_rdata = w_status[i];
            c_OFF_RXDATA: w_rdata = w_rxword[i];
`ifdef STREAM_REGS_IRQ_EN
            c_OFF_CTRL:   w_rdata[c_CTRL_IRQ_EN] = w_irq_en[i];
`endif
            default:      w_rdata = '0;
          endcase
        end
      end
    end
`ifdef STREAM_REGS_IRQ_EN
    else if (reg_addr == c_ADDR_IRQPEND) begin
      w_rdata = 32'(w_pend);
    end
`endif
  end

  // One-cycle acknowledge and registered read data for every request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= reg_req;
      r_rdata <= w_rd ? w_rdata : '0;
    end
  end

  assign reg_ack   = r_ack;
  assign reg_rdata = r_rdata;

`ifdef STREAM_REGS_IRQ_EN
  // Registered interrupt: any enabled channel with pending work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= |w_pend;
  end

  assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_regs
// Description : Self-checking bench for stream_regs: directed scenarios plus
//               randomized traffic checked against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_regs;

  localparam int NCHAN = 2;
  localparam int DEPTH = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               reg_req;
  logic               reg_wr;
  logic [7:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic               reg_ack;
  logic [31:0]        reg_rdata;
  logic [NCHAN-1:0]   tx_valid;
  logic [8*NCHAN-1:0] tx_data;
  logic [NCHAN-1:0]   tx_ready;
  logic [NCHAN-1:0]   rx_valid;
  logic [8*NCHAN-1:0] rx_data;
  logic [NCHAN-1:0]   rx_ready;
`ifdef STREAM_REGS_IRQ_EN
  logic               irq;
`endif

  always #5 clk = ~clk;

  stream_regs #(.NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_req   (reg_req),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready)
`ifdef STREAM_REGS_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: FIFO contents as queues, sticky flags as bits
  logic [7:0]  tx_q [NCHAN][$];
  logic [7:0]  rx_q [NCHAN][$];
  bit          m_ovf [NCHAN];
  bit          m_ien [NCHAN];
  logic [31:0] exp_rdata;
  bit          exp_irq;

  task automatic model_clear();
    for (int c = 0; c < NCHAN; c++) begin
      tx_q[c].delete();
      rx_q[c].delete();
      m_ovf[c] = 1'b0;
      m_ien[c] = 1'b0;
    end
  endtask

  // Advance one clock with the inputs currently driven, updating the model
  task automatic step();
    int          ch;
    int          off;
    bit          mapped;
    int          tx_sz [NCHAN];
    int          rx_sz [NCHAN];
    logic [31:0] rd;
    logic [31:0] pend;
    ch     = int'(reg_addr) / 16;
    off    = int'(reg_addr) % 16;
    mapped = int'(reg_addr) < 16 * NCHAN;
    pend   = '0;
    for (int c = 0; c < NCHAN; c++) begin
      tx_sz[c] = tx_q[c].size();
      rx_sz[c] = rx_q[c].size();
`ifdef STREAM_REGS_IRQ_EN
      if (m_ien[c] && (rx_sz[c] > 0 || m_ovf[c])) pend[c] = 1'b1;
`endif
    end
    exp_irq = (pend != 0);
    rd = '0;
    if (reg_req && !reg_wr) begin
      if (mapped) begin
        case (off)
          4: begin
            rd[0]     = (tx_sz[ch] == 0);
            rd[1]     = (tx_sz[ch] == DEPTH);
            rd[2]     = (rx_sz[ch] > 0);
            rd[3]     = m_ovf[ch];
            rd[15:8]  = 8'(tx_sz[ch]);
            rd[23:16] = 8'(rx_sz[ch]);
          end
          8:  rd = (rx_sz[ch] == 0) ? 32'h8000_0000 : {24'h0, rx_q[ch][0]};
`ifdef STREAM_REGS_IRQ_EN
          12: rd[2] = m_ien[ch];
`endif
          default: rd = '0;
        endcase
      end
`ifdef STREAM_REGS_IRQ_EN
      else if (reg_addr == 8'hFC) rd = pend;
`endif
    end
    exp_rdata = rd;
    for (int c = 0; c < NCHAN; c++)
      if (tx_ready[c] && tx_sz[c] > 0) void'(tx_q[c].pop_front());
    if (reg_req && mapped) begin
      if (reg_wr) begin
        case (off)
          0: if (tx_sz[ch] >= DEPTH) m_ovf[ch] = 1'b1;
             else tx_q[ch].push_back(reg_wdata[7:0]);
          4: if (reg_wdata[3]) m_ovf[ch] = 1'b0;
`ifdef STREAM_REGS_IRQ_EN
          12: m_ien[ch] = reg_wdata[2];
`endif
          default: ;
        endcase
      end else if (off == 8 && rx_sz[ch] > 0) begin
        void'(rx_q[ch].pop_front());
      end
    end
    for (int c = 0; c < NCHAN; c++)
      if (rx_valid[c] && rx_sz[c] < DEPTH) rx_q[c].push_back(rx_data[8*c +: 8]);
    if (reg_req && reg_wr && mapped && off == 12) begin
      if (reg_wdata[0]) tx_q[ch].delete();
      if (reg_wdata[1]) rx_q[ch].delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus access; its ack and read data are visible when this returns
  task automatic bus(input bit wr, input logic [7:0] addr, input logic [31:0] wdata);
    reg_req   = 1'b1;
    reg_wr    = wr;
    reg_addr  = addr;
    reg_wdata = wdata;
    step();
    reg_req   = 1'b0;
    reg_wr    = 1'b0;
  endtask

  task automatic do_reset();
    reg_req   = 1'b0;
    reg_wr    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    tx_ready  = '0;
    rx_valid  = '0;
    rx_data   = '0;
    rst_n     = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (reg_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", reg_ack); else n_pass++;
    n_checks++; if (reg_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", reg_rdata); else n_pass++;
    n_checks++; if (tx_valid !== '0) $display("FAIL reset_tx_valid got %b want 0", tx_valid); else n_pass++;
    n_checks++; if (rx_ready !== '1) $display("FAIL reset_rx_ready got %b want all 1", rx_ready); else n_pass++;
`ifdef STREAM_REGS_IRQ_EN
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
`endif
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_ack !== 1'b1) $display("FAIL reset_read_ack got %b want 1", reg_ack); else n_pass++;
    n_checks++; if (reg_rdata !== 32'h0000_0001) $display("FAIL reset_status got %h want 00000001", reg_rdata); else n_pass++;
    bus(1'b0, 8'h08, 32'h0);
    n_checks++; if (reg_rdata !== 32'h8000_0000) $display("FAIL reset_rxdata got %h want 80000000", reg_rdata); else n_pass++;
  endtask

  task automatic test_tx_overflow();
    tx_ready = '0;
    for (int i = 0; i <= 16; i++) bus(1'b1, 8'h00, 32'(i));
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_100A) $display("FAIL ovf_status got %h want 0000100a", reg_rdata); else n_pass++;
    tx_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (tx_valid[0] !== 1'b1 || tx_data[7:0] !== 8'(i))
        $display("FAIL tx_drain[%0d] got valid=%b data=%h want valid=1 data=%h", i, tx_valid[0], tx_data[7:0], 8'(i));
      else n_pass++;
      step();
    end
    tx_ready[0] = 1'b0;
    n_checks++; if (tx_valid[0] !== 1'b0) $display("FAIL tx_drain_end got valid=%b want 0", tx_valid[0]); else n_pass++;
    bus(1'b1, 8'h04, 32'h8);
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0001) $display("FAIL ovf_clear got %h want 00000001", reg_rdata); else n_pass++;
  endtask

  task automatic test_rx_channel1();
    rx_valid[1] = 1'b1;
    rx_data[15:8] = 8'h41;
    step();
    rx_data[15:8] = 8'h42;
    step();
    rx_valid[1] = 1'b0;
    bus(1'b0, 8'h18, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0041) $display("FAIL rx1_first got %h want 00000041", reg_rdata); else n_pass++;
    bus(1'b0, 8'h18, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0042) $display("FAIL rx1_second got %h want 00000042", reg_rdata); else n_pass++;
    bus(1'b0, 8'h18, 32'h0);
    n_checks++; if (reg_rdata !== 32'h8000_0000) $display("FAIL rx1_empty got %h want 80000000", reg_rdata); else n_pass++;
  endtask

  task automatic test_rx_full();
    rx_valid[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data[7:0] = 8'(8'h60 + i);
      step();
    end
    n_checks++; if (rx_ready[0] !== 1'b0) $display("FAIL rx_full_ready got %b want 0", rx_ready[0]); else n_pass++;
    rx_valid[0] = 1'b0;
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0010_0005) $display("FAIL rx_full_status got %h want 00100005", reg_rdata); else n_pass++;
    bus(1'b0, 8'h08, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0060) $display("FAIL rx_full_head got %h want 00000060", reg_rdata); else n_pass++;
    n_checks++; if (rx_ready[0] !== 1'b1) $display("FAIL rx_ready_after_pop got %b want 1", rx_ready[0]); else n_pass++;
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h000F_0005) $display("FAIL rx_count_15 got %h want 000f0005", reg_rdata); else n_pass++;
    rx_valid[0] = 1'b1;
    rx_data[7:0] = 8'h70;
    step();
    rx_valid[0] = 1'b0;
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0010_0005) $display("FAIL rx_refill got %h want 00100005", reg_rdata); else n_pass++;
    bus(1'b1, 8'h0C, 32'h2);
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0001) $display("FAIL rx_flush got %h want 00000001", reg_rdata); else n_pass++;
  endtask

  task automatic test_same_cycle();
    tx_ready = '0;
    for (int i = 0; i < 5; i++) bus(1'b1, 8'h00, 32'(8'hA0 + i));
    tx_ready[0] = 1'b1;
    bus(1'b1, 8'h00, 32'hA5);
    tx_ready[0] = 1'b0;
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0500) $display("FAIL push_pop_count got %h want 00000500", reg_rdata); else n_pass++;
    n_checks++; if (tx_data[7:0] !== 8'hA1) $display("FAIL push_pop_head got %h want a1", tx_data[7:0]); else n_pass++;
    tx_ready[0] = 1'b1;
    bus(1'b1, 8'h0C, 32'h1);
    n_checks++; if (tx_valid[0] !== 1'b0) $display("FAIL tx_flush_valid got %b want 0", tx_valid[0]); else n_pass++;
    tx_ready[0] = 1'b0;
    bus(1'b0, 8'h04, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0001) $display("FAIL tx_flush_status got %h want 00000001", reg_rdata); else n_pass++;
  endtask

  task automatic test_irq();
    bus(1'b1, 8'h0C, 32'h4);
    bus(1'b0, 8'h0C, 32'h0);
`ifdef STREAM_REGS_IRQ_EN
    n_checks++; if (reg_rdata !== 32'h4) $display("FAIL ctrl_ien_read got %h want 00000004", reg_rdata); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq); else n_pass++;
    rx_valid[0] = 1'b1;
    rx_data[7:0] = 8'h5A;
    step();
    rx_valid[0] = 1'b0;
    step();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_raise got %b want 1", irq); else n_pass++;
    bus(1'b0, 8'hFC, 32'h0);
    n_checks++; if (reg_rdata !== 32'h1) $display("FAIL irqpend got %h want 00000001", reg_rdata); else n_pass++;
    bus(1'b0, 8'h08, 32'h0);
    n_checks++; if (reg_rdata !== 32'h5A) $display("FAIL irq_rxdata got %h want 0000005a", reg_rdata); else n_pass++;
    step();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_drop got %b want 0", irq); else n_pass++;
    bus(1'b1, 8'h0C, 32'h0);
`else
    n_checks++; if (reg_rdata !== 32'h0) $display("FAIL ctrl_ien_absent got %h want 0", reg_rdata); else n_pass++;
    bus(1'b0, 8'hFC, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0) $display("FAIL irqpend_unmapped got %h want 0", reg_rdata); else n_pass++;
`endif
  endtask

  task automatic test_unmapped();
    bus(1'b1, 8'h20, 32'h55);
    n_checks++; if (reg_ack !== 1'b1) $display("FAIL unmapped_wr_ack got %b want 1", reg_ack); else n_pass++;
    n_checks++; if (tx_valid !== '0) $display("FAIL unmapped_wr_effect got %b want 0", tx_valid); else n_pass++;
    bus(1'b0, 8'h20, 32'h0);
    n_checks++; if (reg_ack !== 1'b1 || reg_rdata !== 32'h0) $display("FAIL unmapped_rd got ack=%b data=%h want ack=1 data=0", reg_ack, reg_rdata); else n_pass++;
    bus(1'b0, 8'h05, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0) $display("FAIL odd_offset got %h want 0", reg_rdata); else n_pass++;
    bus(1'b0, 8'h00, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0) $display("FAIL txdata_read got %h want 0", reg_rdata); else n_pass++;
  endtask

  task automatic test_random();
    bit was_req;
    bit was_rd;
    int sel;
    for (int n = 0; n < 3000; n++) begin
      tx_ready = NCHAN'($urandom);
      rx_valid = NCHAN'($urandom);
      rx_data  = (8*NCHAN)'($urandom);
      reg_req  = ($urandom_range(0, 3) != 0);
      reg_wr   = $urandom_range(0, 1) == 1;
      sel      = int'($urandom_range(0, 19));
      if (sel == 19) reg_addr = 8'hFC;
      else reg_addr = 8'(16 * $urandom_range(0, NCHAN) + 4 * $urandom_range(0, 3));
      reg_wdata = $urandom;
      if (reg_addr[3:0] == 4'hC && $urandom_range(0, 9) != 0) reg_wdata[1:0] = 2'b00;
      was_req = reg_req;
      was_rd  = reg_req && !reg_wr;
      step();
      n_checks++; if (reg_ack !== was_req) $display("FAIL rand_ack[%0d] got %b want %b", n, reg_ack, was_req); else n_pass++;
      if (was_rd) begin
        n_checks++; if (reg_rdata !== exp_rdata) $display("FAIL rand_rdata[%0d] got %h want %h", n, reg_rdata, exp_rdata); else n_pass++;
      end
      for (int c = 0; c < NCHAN; c++) begin
        n_checks++;
        if (tx_valid[c] !== (tx_q[c].size() > 0)) $display("FAIL rand_tx_valid[%0d] ch%0d got %b want %b", n, c, tx_valid[c], tx_q[c].size() > 0);
        else n_pass++;
        if (tx_q[c].size() > 0) begin
          n_checks++;
          if (tx_data[8*c +: 8] !== tx_q[c][0]) $display("FAIL rand_tx_data[%0d] ch%0d got %h want %h", n, c, tx_data[8*c +: 8], tx_q[c][0]);
          else n_pass++;
        end
        n_checks++;
        if (rx_ready[c] !== (rx_q[c].size() < DEPTH)) $display("FAIL rand_rx_ready[%0d] ch%0d got %b want %b", n, c, rx_ready[c], rx_q[c].size() < DEPTH);
        else n_pass++;
      end
`ifdef STREAM_REGS_IRQ_EN
      n_checks++; if (irq !== exp_irq) $display("FAIL rand_irq[%0d] got %b want %b", n, irq, exp_irq); else n_pass++;
`endif
    end
    reg_req  = 1'b0;
    reg_wr   = 1'b0;
    tx_ready = '0;
    rx_valid = '0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) bus(1'b1, 8'h10, 32'(8'hC0 + i));
    reg_req  = 1'b1;
    reg_wr   = 1'b0;
    reg_addr = 8'h14;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (reg_ack !== 1'b0) $display("FAIL mid_reset_ack got %b want 0", reg_ack); else n_pass++;
    reg_req = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_valid !== '0) $display("FAIL mid_reset_tx_valid got %b want 0", tx_valid); else n_pass++;
    bus(1'b0, 8'h14, 32'h0);
    n_checks++; if (reg_rdata !== 32'h0000_0001) $display("FAIL mid_reset_status got %h want 00000001", reg_rdata); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_overflow();
    test_rx_channel1();
    test_rx_full();
    test_same_cycle();
    test_irq();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_regs.md
Name: stream_regs

Overview:
- Parametrised memory-mapped register bridge between the soft-CPU register bus and NCHAN byte-stream peripherals (UART, keyboard, future ports).
- Each channel has a TX FIFO (CPU→device) and an RX FIFO (device→CPU), plus status and control registers.
- Adds buffering, occupancy counts, sticky overflow, flush and optional interrupt.
- Sits between the bus decoder and the peripheral stream endpoints.

Parameters:
- NCHAN, 2, number of channels; legal 1..8.
- DEPTH, 16, entries per FIFO; power of 2, legal 2..128.
- CW, $clog2(DEPTH)+1, count width; derived, not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- reg_req  in  1  bus request, one-cycle pulse per access
- reg_wr  in  1  1=write, 0=read
- reg_addr  in  8  byte address
- reg_wdata  in  32  write data
- reg_ack  out  1  access complete
- reg_rdata  out  32  read data, valid with reg_ack
- tx_valid  out  NCHAN  per-channel TX byte available
- tx_data  out  8*NCHAN  TX byte; channel c at [8c+7:8c]
- tx_ready  in  NCHAN  device accepts TX byte
- rx_valid  in  NCHAN  device offers RX byte
- rx_data  in  8*NCHAN  RX byte; channel c at [8c+7:8c]
- rx_ready  out  NCHAN  RX FIFO can accept
- irq  out  1  interrupt; present only with STREAM_REGS_IRQ_EN

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: reg_ack=0, reg_rdata=0, all FIFOs empty, ovf flags=0, irq enables=0, irq=0.
- Bus timing: reg_ack is asserted the cycle after reg_req, for every request including unmapped addresses. Back-to-back requests on consecutive cycles are legal. Read data is registered: 1-cycle latency.
- Address map: channel c base = 0x10*c; addr[3:0] selects the register. Addresses at or above 0x10*NCHAN are unmapped: reads return 0, writes are ignored.
- +0x0 TXDATA (write): pushes wdata[7:0] into TX FIFO.
  - If the FIFO is full at that cycle's start, the byte is dropped and tx_ovf is set.
  - A same-cycle device pop does not rescue a full-FIFO write.
  - Read returns 0.
- +0x4 STATUS (read): bit0 tx_empty, bit1 tx_full, bit2 rx_nonempty, bit3 tx_ovf, [15:8] tx_count (zero-extended), [23:16] rx_count, other bits 0.
  - Write with wdata[3]=1 clears tx_ovf. If a drop occurs in the same cycle, set wins.
- +0x8 RXDATA (read): returns {rx_empty, 23'b0, head byte}.
  - Pops only if nonempty. Empty read returns 0x8000_0000 and pops nothing.
  - Writes are ignored.
- +0xC CTRL: bit0 TX flush, bit1 RX flush (both self-clearing, read as 0); bit2 irq enable (read/write).
  - Flush empties the FIFO in one cycle and wins over any same-cycle push or pop.
- TX side: tx_valid = TX FIFO nonempty; tx_data = head (show-ahead). Pop on tx_valid && tx_ready. Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
- RX side: rx_ready = (rx_count < DEPTH), derived from registered count. Push on rx_valid && rx_ready. No RX overflow is possible; the device is back-pressured.
- Counts range 0..DEPTH. Pointers are log2(DEPTH) bits and wrap naturally.
- Reset asserted mid-access: the pending ack is lost and FIFO contents are discarded.

Optional Feature:
- Macro STREAM_REGS_IRQ_EN.
- Defined:
  - irq is registered and high while any channel has CTRL bit2=1 and (rx_nonempty or tx_ovf).
  - Global register 0xFC read returns the per-channel pending mask in [NCHAN-1:0].
- Undefined:
  - irq port is absent; CTRL bit2 reads 0; 0xFC is unmapped.

Decomposition:
- Package stream_regs_pkg: register offsets (TXDATA=0x0, STATUS=0x4, RXDATA=0x8, CTRL=0xC, IRQPEND=0xFC), STATUS bit positions, CTRL bit positions.
- Sub-module byte_fifo, instantiated 2*NCHAN times:
  - params DEPTH
  - ports clk, rst_n, flush, push, din, pop, dout, count, full, empty
  - show-ahead output

Test Plan:
1. After reset, read 0x04 → 0x0000_0001; read 0x08 → 0x8000_0000; tx_valid=0; rx_ready all 1.
2. DEPTH=16, tx_ready=0: write 17 bytes 0x00..0x10 to 0x00 → STATUS=0x0000_100A (count 16, full, ovf). Raise tx_ready → bytes 0x00..0x0F emerge in order; 0x10 is lost.
3. Drive rx_valid on ch1 with 0x41,0x42 → read 0x18 → 0x0000_0041, then 0x0000_0042, then 0x8000_0000.
4. Fill ch0 RX (16 bytes) → rx_ready[0]=0, held until one RXDATA read; rx_count then reads 15, refills to 16.
5. Same-cycle TXDATA write and device pop at count 5 → count stays 5. CTRL write 0x1 while tx_ready=1 → count 0, tx_valid=0 next cycle.
6. With STREAM_REGS_IRQ_EN: CTRL ch0=0x4, push RX byte → irq=1 and 0xFC reads 0x1. Read RXDATA → irq=0.
